// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices,
// the NOP encoding loaded on a bubble, and the PC width.
package pipe_ctrl_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int PC_W = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_redirect_reg.sv
// Registered redirect toward fetch: a new load always wins over the
// ready handshake and overwrites any PC still pending.
module pipe_redirect_reg
    import pipe_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Merges stall, multi-cycle bubble and flush requests into per-stage
// stall/bubble/flush controls; owns the fetch redirect and perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES    = 5,
    parameter int BUB_STAGE = STG_ID,
    parameter int BUB_W     = 3,
    parameter int CNT_W     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [STAGES-1:0]      stallreq_i,
    input  logic                   bub_req_i,
    input  logic [BUB_W-1:0]       bub_len_i,
    input  logic [STAGES-1:0]      flushreq_i,
    input  logic [STAGES*PC_W-1:0] flush_pc_i,
    input  logic                   redir_ready_i,
    output logic [STAGES-1:0]      stall_o,
    output logic [STAGES-1:0]      bubble_o,
    output logic [STAGES-1:0]      flush_o,
    output logic                   redir_valid_o,
    output logic [PC_W-1:0]        redir_pc_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
);

    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [IDX_W-1:0] BUB_IDX = IDX_W'(BUB_STAGE);

    function automatic logic [IDX_W-1:0] msb_idx(input logic [STAGES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < STAGES; i++)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    logic [BUB_W-1:0]  bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [STAGES-1:0] eff_req;
    logic [IDX_W-1:0]  src_idx, flush_idx;
    logic              src_hit, flush_hit, flush_acc;
    logic              redir_valid;
    logic [PC_W-1:0]   sel_pc;

    // An active bubble and an unacknowledged redirect behave like stall
    // requests from ID and IF respectively.
    always_comb begin
        eff_req = stallreq_i;
        if (bub_cnt_q != '0 || bub_req_i) eff_req[BUB_STAGE] = 1'b1;
        if (redir_valid && !redir_ready_i) eff_req[0] = 1'b1;
    end

    assign src_hit   = |eff_req;
    assign src_idx   = msb_idx(eff_req);
    assign flush_hit = |flushreq_i;
    assign flush_idx = msb_idx(flushreq_i);
    assign flush_acc = !rst_i && flush_hit && !(src_hit && src_idx >= flush_idx);

    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        flush_o  = '0;
        sel_pc   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (!rst_i) begin
                if (src_hit && IDX_W'(k) <= src_idx) stall_o[k] = 1'b1;
                if (src_hit && k > 0 && IDX_W'(k - 1) == src_idx) bubble_o[k] = 1'b1;
                if (flush_acc && IDX_W'(k) < flush_idx) begin
                    flush_o[k]  = 1'b1;
                    stall_o[k]  = 1'b0;
                    bubble_o[k] = 1'b0;
                end
            end
            if (IDX_W'(k) == flush_idx) sel_pc = flush_pc_i[k*PC_W +: PC_W];
        end
    end

    always_comb begin
        if (flush_acc && flush_idx >= BUB_IDX)
            bub_cnt_d = '0;
        else if (bub_cnt_q != '0)
            bub_cnt_d = bub_cnt_q - BUB_W'(1);
        else if (bub_req_i)
            bub_cnt_d = (bub_len_i == '0) ? '0 : bub_len_i - BUB_W'(1);
        else
            bub_cnt_d = bub_cnt_q;

        stall_cnt_d = stall_cnt_q + CNT_W'(stall_o[0]);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_acc);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bub_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            bub_cnt_q   <= bub_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    pipe_redirect_reg u_redir (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (flush_acc),
        .pc_i    (sel_pc),
        .ready_i (redir_ready_i),
        .valid_o (redir_valid),
        .pc_o    (redir_pc_o)
    );

    assign redir_valid_o = redir_valid;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
